// File: rtl/tissue_readout_if.sv
// Serial cell-status stream bundle.
// master: drives status_out/valid/last/x/y and samples status_ready.
// slave : the reverse (downstream consumer).
interface tissue_readout_if #(
    parameter int unsigned TISSUE_WIDTH  = 30,
    parameter int unsigned TISSUE_HEIGHT = 3
);
    localparam int unsigned XW = (TISSUE_WIDTH > 1) ? $clog2(TISSUE_WIDTH) : 1;
    localparam int unsigned YW = (TISSUE_HEIGHT > 1) ? $clog2(TISSUE_HEIGHT) : 1;

    logic          status_out;
    logic          status_valid;
    logic          status_ready;
    logic          status_last;
    logic [XW-1:0] status_x;
    logic [YW-1:0] status_y;

    modport master (
        output status_out,
        output status_valid,
        output status_last,
        output status_x,
        output status_y,
        input  status_ready
    );

    modport slave (
        input  status_out,
        input  status_valid,
        input  status_last,
        input  status_x,
        input  status_y,
        output status_ready
    );
endinterface

// File: rtl/tissue_readout.sv
// Snapshot-and-serialise readout of a 2-D tissue status array.
// On capture (while idle) the whole cell_status_in vector is latched, then streamed one bit per
// accepted transfer in row-major order over a valid/ready interface.
// Ports:
//   clk, rst          - clock, asynchronous active-high reset
//   capture           - snapshot request (ignored while streaming; pulses capture_dropped)
//   cell_status_in    - live state, bit index y*TISSUE_WIDTH+x
//   status_if         - stream: status_out/valid/last/x/y out, status_ready in
//   busy              - high while streaming
//   capture_dropped   - one-cycle pulse after an ignored capture
//   occupancy_count/valid - count of streamed 1-bits for the last frame
// Optional feature: define TISSUE_READOUT_OCCUPANCY_EN to enable occupancy counting; otherwise
// the occupancy outputs are tied to 0.
module tissue_readout #(
    parameter int unsigned TISSUE_WIDTH  = 30,
    parameter int unsigned TISSUE_HEIGHT = 3
) (
    input  logic                                             clk,
    input  logic                                             rst,
    input  logic                                             capture,
    input  logic [TISSUE_WIDTH*TISSUE_HEIGHT-1:0]            cell_status_in,
    tissue_readout_if.master                                 status_if,
    output logic                                             busy,
    output logic                                             capture_dropped,
    output logic [$clog2(TISSUE_WIDTH*TISSUE_HEIGHT+1)-1:0]  occupancy_count,
    output logic                                             occupancy_valid
);
    localparam int unsigned N  = TISSUE_WIDTH * TISSUE_HEIGHT;
    localparam int unsigned XW = (TISSUE_WIDTH > 1) ? $clog2(TISSUE_WIDTH) : 1;
    localparam int unsigned YW = (TISSUE_HEIGHT > 1) ? $clog2(TISSUE_HEIGHT) : 1;
    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned CW = $clog2(N + 1);

    localparam logic ST_IDLE   = 1'b0;
    localparam logic ST_STREAM = 1'b1;

    localparam logic [XW-1:0] X_MAX   = XW'(TISSUE_WIDTH - 1);
    localparam logic [YW-1:0] Y_MAX   = YW'(TISSUE_HEIGHT - 1);
    localparam logic [IW-1:0] ROW_LEN = IW'(TISSUE_WIDTH);

    logic          state_q, state_d;
    logic [N-1:0]  snap_q, snap_d;
    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;
    logic          drop_q, drop_d;

    logic          streaming;
    logic          at_last;
    logic          fire;
    logic          accept;
    logic [IW-1:0] bit_idx;
    logic          cur_bit;

    assign streaming = (state_q == ST_STREAM);
    assign at_last   = streaming && (x_q == X_MAX) && (y_q == Y_MAX);
    assign fire      = streaming && status_if.status_ready;
    assign accept    = !streaming && capture;
    assign bit_idx   = IW'(y_q) * ROW_LEN + IW'(x_q);
    assign cur_bit   = streaming && snap_q[bit_idx];

    always_comb begin
        state_d = state_q;
        snap_d  = snap_q;
        x_d     = x_q;
        y_d     = y_q;
        drop_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (capture) begin
                    snap_d  = cell_status_in;
                    x_d     = '0;
                    y_d     = '0;
                    state_d = ST_STREAM;
                end
            end
            ST_STREAM: begin
                // A capture during streaming, even on the last transfer, is rejected.
                drop_d = capture;
                if (status_if.status_ready) begin
                    if (at_last) begin
                        // Coordinates return to 0 so idle outputs read (0,0).
                        state_d = ST_IDLE;
                        x_d     = '0;
                        y_d     = '0;
                    end else if (x_q == X_MAX) begin
                        x_d = '0;
                        y_d = y_q + 1'b1;
                    end else begin
                        x_d = x_q + 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            snap_q  <= '0;
            x_q     <= '0;
            y_q     <= '0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            snap_q  <= snap_d;
            x_q     <= x_d;
            y_q     <= y_d;
            drop_q  <= drop_d;
        end
    end

    // Outputs derive from state flops so reset clears them without waiting for a clock.
    assign status_if.status_out   = cur_bit;
    assign status_if.status_valid = streaming;
    assign status_if.status_last  = at_last;
    assign status_if.status_x     = x_q;
    assign status_if.status_y     = y_q;
    assign busy                   = streaming;
    assign capture_dropped        = drop_q;

`ifdef TISSUE_READOUT_OCCUPANCY_EN
    logic [CW-1:0] occ_cnt_q, occ_cnt_d;
    logic          occ_valid_q, occ_valid_d;

    always_comb begin
        occ_cnt_d   = occ_cnt_q;
        occ_valid_d = occ_valid_q;
        if (accept) begin
            occ_cnt_d   = '0;
            occ_valid_d = 1'b0;
        end else if (fire) begin
            if (cur_bit) begin
                occ_cnt_d = occ_cnt_q + CW'(1);
            end
            if (at_last) begin
                occ_valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            occ_cnt_q   <= '0;
            occ_valid_q <= 1'b0;
        end else begin
            occ_cnt_q   <= occ_cnt_d;
            occ_valid_q <= occ_valid_d;
        end
    end

    assign occupancy_count = occ_cnt_q;
    assign occupancy_valid = occ_valid_q;
`else
    logic unused_occ;
    assign unused_occ      = accept ^ fire;
    assign occupancy_count = '0;
    assign occupancy_valid = 1'b0;
`endif
endmodule

// File: tb/tb_tissue_readout.sv
// Bench for tissue_readout: table of frame scenarios plus reset/drop sequences, checked against
// a row-major bit list built from each snapshot.
module tb_tissue_readout;
    localparam int W = 30;
    localparam int H = 3;
    localparam int N = W * H;
    localparam int CW = $clog2(N + 1);

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          capture = 1'b0;
    logic [N-1:0]  cell_status_in = '0;
    logic          busy;
    logic          capture_dropped;
    logic [CW-1:0] occupancy_count;
    logic          occupancy_valid;

    int total = 0;
    int bad   = 0;

    tissue_readout_if #(.TISSUE_WIDTH(W), .TISSUE_HEIGHT(H)) sif ();

    tissue_readout #(.TISSUE_WIDTH(W), .TISSUE_HEIGHT(H)) dut (
        .clk             (clk),
        .rst             (rst),
        .capture         (capture),
        .cell_status_in  (cell_status_in),
        .status_if       (sif),
        .busy            (busy),
        .capture_dropped (capture_dropped),
        .occupancy_count (occupancy_count),
        .occupancy_valid (occupancy_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0] snap;
        int           mode;       // 0 ready=1, 1 toggle, 2 random
        bit           inj;        // inject captures at bit 40 and at the last bit
        int           exp_cycles; // 0 = not checked
    } frame_t;

    frame_t tbl[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_valid"}, 32'(sif.status_valid), 0);
        check({tag, "_out"}, 32'(sif.status_out), 0);
        check({tag, "_last"}, 32'(sif.status_last), 0);
        check({tag, "_x"}, 32'(sif.status_x), 0);
        check({tag, "_y"}, 32'(sif.status_y), 0);
        check({tag, "_busy"}, 32'(busy), 0);
    endtask

    task automatic check_occ(input string tag, input int cnt, input bit vld);
`ifdef TISSUE_READOUT_OCCUPANCY_EN
        check({tag, "_occ_cnt"}, 32'(occupancy_count), 32'(cnt));
        check({tag, "_occ_vld"}, 32'(occupancy_valid), 32'(vld));
`else
        check({tag, "_occ_cnt"}, 32'(occupancy_count), 0);
        check({tag, "_occ_vld"}, 32'(occupancy_valid), 0);
`endif
    endtask

    // Capture snap, invert the live input, then stream the whole frame. Entered/left at negedge.
    task automatic run_frame(input logic [N-1:0] snap, input int mode, input bit inj,
                             input int exp_cycles, input string tag);
        bit exp_bits[$];
        int i = 0;
        int cycles = 0;
        int guard = 0;
        int ones = 0;
        bit rdy;
        bit drop_exp = 1'b0;
        for (int k = 0; k < N; k++) exp_bits.push_back(snap[k]);
        cell_status_in = snap;
        capture = 1'b1;
        @(posedge clk);
        @(negedge clk);
        capture = 1'b0;
        cell_status_in = ~snap;
        while (i < N && guard < 4 * N) begin
            check({tag, "_valid"}, 32'(sif.status_valid), 1);
            check({tag, "_bit"}, 32'(sif.status_out), 32'(exp_bits[i]));
            check({tag, "_x"}, 32'(sif.status_x), 32'(i % W));
            check({tag, "_y"}, 32'(sif.status_y), 32'(i / W));
            check({tag, "_last"}, 32'(sif.status_last), 32'(i == N - 1));
            check({tag, "_busy"}, 32'(busy), 1);
            check({tag, "_drop"}, 32'(capture_dropped), 32'(drop_exp));
            check_occ(tag, ones, 1'b0);
            cycles++;
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = (cycles % 2) == 1;
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            sif.status_ready = rdy;
            capture = inj && rdy && (i == 40 || i == N - 1);
            drop_exp = capture;
            @(posedge clk);
            if (rdy) begin
                ones += int'(exp_bits[i]);
                i++;
            end
            @(negedge clk);
            guard++;
        end
        check({tag, "_frame_done"}, 32'(i), 32'(N));
        capture = 1'b0;
        sif.status_ready = 1'b0;
        check_idle({tag, "_end"});
        check({tag, "_end_drop"}, 32'(capture_dropped), 32'(drop_exp));
        check_occ({tag, "_end"}, ones, 1'b1);
        if (exp_cycles != 0) check({tag, "_cycles"}, 32'(cycles), 32'(exp_cycles));
        @(negedge clk);
        check({tag, "_post_drop"}, 32'(capture_dropped), 0);
        check({tag, "_post_valid"}, 32'(sif.status_valid), 0);
        check_occ({tag, "_post"}, ones, 1'b1);
    endtask

    initial begin
        logic [N-1:0] alt = '0;
        logic [N-1:0] s17 = '0;
        logic [N-1:0] r;
        for (int x = 0; x < W; x += 2) alt[x] = 1'b1;
        for (int k = 0; k < 17; k++) s17[k * 5] = 1'b1;
        tbl[0] = '{snap: alt, mode: 0, inj: 1'b0, exp_cycles: N};
        tbl[1] = '{snap: alt, mode: 1, inj: 1'b0, exp_cycles: 2 * N - 1};
        tbl[2] = '{snap: alt, mode: 0, inj: 1'b1, exp_cycles: N};
        tbl[3] = '{snap: s17, mode: 0, inj: 1'b0, exp_cycles: N};
        for (int t = 4; t < 6; t++) begin
            r = N'({$urandom, $urandom, $urandom});
            tbl[t] = '{snap: r, mode: 2, inj: 1'b0, exp_cycles: 0};
        end

        sif.status_ready = 1'b0;
        #1 rst = 1'b1;
        #2;
        check_idle("reset");
        check("reset_drop", 32'(capture_dropped), 0);
        check_occ("reset", 0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_idle("idle");

        for (int t = 0; t < 6; t++) begin
            run_frame(tbl[t].snap, tbl[t].mode, tbl[t].inj, tbl[t].exp_cycles,
                      $sformatf("frame%0d", t));
        end

        // Asynchronous reset mid-frame at bit 50.
        cell_status_in = alt;
        capture = 1'b1;
        @(posedge clk);
        @(negedge clk);
        capture = 1'b0;
        sif.status_ready = 1'b1;
        repeat (50) @(negedge clk);
        check("rst_mid_x", 32'(sif.status_x), 32'(50 % W));
        check("rst_mid_y", 32'(sif.status_y), 32'(50 / W));
        #2 rst = 1'b1;
        #1;
        check_idle("rst_mid");
        check("rst_mid_drop", 32'(capture_dropped), 0);
        check_occ("rst_mid", 0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check_idle("rst_after");
        end
        sif.status_ready = 1'b0;
        run_frame(s17, 0, 1'b0, N, "restart");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/tissue_readout.md
TISSUE_READOUT -- requirements
Module: tissue_readout

Interface
REQ-001 SHALL have parameter TISSUE_WIDTH, default 30, cells per row.
REQ-002 SHALL have parameter TISSUE_HEIGHT, default 3, number of rows.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port capture  input  1  snapshot request; sampled on posedge clk.
REQ-006 SHALL have port cell_status_in  input  TISSUE_WIDTH*TISSUE_HEIGHT  live tissue state; bit index y*TISSUE_WIDTH+x.
REQ-007 SHALL have port status_ready  input  1  downstream accepts a bit.
REQ-008 SHALL have port status_out  output  1  current serial cell status bit.
REQ-009 SHALL have port status_valid  output  1  status_out holds a valid bit.
REQ-010 SHALL have port status_last  output  1  current bit is cell (TISSUE_WIDTH-1, TISSUE_HEIGHT-1).
REQ-011 SHALL have ports status_x and status_y  output  $clog2(TISSUE_WIDTH) and $clog2(TISSUE_HEIGHT)  coordinates of current bit.
REQ-012 SHALL have port busy  output  1  high while in STREAM.
REQ-013 SHALL have port capture_dropped  output  1  one-cycle pulse when a capture is ignored.
REQ-014 SHALL have ports occupancy_count  output  $clog2(TISSUE_WIDTH*TISSUE_HEIGHT+1)  and occupancy_valid  output  1.

Function
REQ-015 SHALL implement FSM with states IDLE and STREAM.
REQ-016 In IDLE, capture=1 at a rising edge SHALL latch cell_status_in into an internal snapshot, clear x/y to 0, and enter STREAM.
REQ-017 In STREAM, status_valid SHALL be 1 and status_out SHALL equal snapshot bit at (status_x, status_y), starting the cycle after capture.
REQ-018 A transfer SHALL occur on a rising edge where status_valid and status_ready are both 1; no transfer otherwise; outputs SHALL be held stable while status_ready=0.
REQ-019 Order SHALL be row-major: x increments 0..TISSUE_WIDTH-1, then wraps to 0 with y+1; identical to the serial init load order of tissue.
REQ-020 status_last SHALL be 1 exactly when x=TISSUE_WIDTH-1 and y=TISSUE_HEIGHT-1 in STREAM.
REQ-021 Transfer of the last bit SHALL return FSM to IDLE; status_valid SHALL be 0 the following cycle.
REQ-022 capture=1 while in STREAM (including the cycle of the last transfer) SHALL be ignored, leave snapshot unchanged, and pulse capture_dropped for one cycle.
REQ-023 Changes on cell_status_in after capture SHALL NOT affect the streamed bits.
REQ-024 In IDLE, status_out, status_valid, status_last SHALL be 0; status_x/status_y SHALL hold 0.
REQ-025 A full frame SHALL take TISSUE_WIDTH*TISSUE_HEIGHT transfers; with status_ready held 1, busy high for exactly that many cycles.

Reset
REQ-026 rst=1 SHALL immediately force IDLE, and status_out, status_valid, status_last, status_x, status_y, busy, capture_dropped, occupancy_count, occupancy_valid to 0, regardless of clk.
REQ-027 Reset mid-STREAM SHALL abandon the frame; no further bits until a new capture after rst deasserts.

Configuration
REQ-028 Macro TISSUE_READOUT_OCCUPANCY_EN SHALL, when defined, enable counting of 1-bits transferred during a frame: counter cleared on accepted capture, incremented per transferred 1, occupancy_valid=1 from the cycle after the last transfer until the next accepted capture, count held stable meanwhile.
REQ-029 Without TISSUE_READOUT_OCCUPANCY_EN, occupancy_count and occupancy_valid SHALL remain present and tied to 0.

Verification
REQ-030 W=30,H=3, snapshot row0=alternating 1010..., rows1-2 zero, ready=1 -> 90 bits in row-major order, status_last only on bit 90, busy high 90 cycles.
REQ-031 ready toggled 1/0 every cycle during frame -> same 90-bit sequence, status_out/x/y stable on ready=0 cycles, frame spans 179 cycles.
REQ-032 capture pulsed at bit 40 and coincident with last transfer -> two capture_dropped pulses, stream unchanged.
REQ-033 cell_status_in inverted one cycle after capture -> streamed bits match original snapshot.
REQ-034 rst asserted asynchronously at bit 50 -> all outputs 0 same instant; new capture restarts at (0,0).
REQ-035 With TISSUE_READOUT_OCCUPANCY_EN, 17 ones in snapshot -> occupancy_count=17, occupancy_valid=1 after last transfer; without macro both stay 0.
